// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute boundary of the pipelined RV32I core. It holds the ID/EX
// pipeline register, detects load-use hazards against the instruction in EX,
// and sequences the ECALL halt drain.
//
// Parameters
//   HALT_DRAIN  cycles from a halting ECALL leaving ID until it retires (>= 1)
//   HALT_REG    register ECALL reads implicitly (steered onto rs1 upstream)
//   HALT_CODE   value of HALT_REG that turns ECALL into a halt
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_*                  decoded instruction, operands, immediate, controls
//   ex_*                  registered EX-side copies (bubble = all zero)
//   stall                 combinational; freezes PC and IF/ID
//   is_halted             registered, sticky until reset
//   bubble_count          number of load-use bubbles inserted (wraps)
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned HALT_DRAIN = 3,
  parameter int unsigned HALT_REG   = 17,
  parameter int unsigned HALT_CODE  = 10
) (
  input  logic        clk,
  input  logic        reset,
  // ID side
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_reg_write,
  input  logic        id_alu_src,
  input  logic [1:0]  id_alu_op,
  // EX side
  output logic        ex_valid,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_reg_write,
  output logic        ex_alu_src,
  output logic [1:0]  ex_alu_op,
  // Status
  output logic        stall,
  output logic        is_halted,
  output logic [31:0] bubble_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Counter only has to hold HALT_DRAIN-1.
  localparam int unsigned      CNT_W       = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [CNT_W-1:0] DRAIN_INIT  = CNT_W'(HALT_DRAIN - 1);
  localparam logic [4:0]       HALT_REG_IX = 5'(HALT_REG);
  localparam logic [31:0]      HALT_CODE_W = 32'(HALT_CODE);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src;
    logic [1:0]  alu_op;
  } ex_reg_t;

  state_e           state_q;
  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  logic [CNT_W-1:0] drain_cnt_q;
  logic             is_halted_q;
  logic [31:0]      bubble_q;

  // -------------------------------------------------------------------------
  // Decode of source-register usage
  // -------------------------------------------------------------------------
  logic [6:0] opcode;
  logic       is_ecall;
  logic       uses_rs1;
  logic       uses_rs2;
  logic [4:0] rs1_eff;
  logic       load_in_ex;
  logic       hz;
  logic       halt_now;

  assign opcode = id_inst[6:0];

  // rd and rs1 fields are ignored for ECALL; upstream steers HALT_REG instead.
  assign is_ecall = (opcode == OP_SYSTEM) && (id_inst[14:12] == 3'b000) &&
                    (id_inst[31:20] == 12'h000);

  assign uses_rs1 = (opcode == OP_R) || (opcode == OP_IMM) ||
                    (opcode == OP_LOAD) || (opcode == OP_STORE) || is_ecall;
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE);
  assign rs1_eff  = is_ecall ? HALT_REG_IX : id_inst[19:15];

  assign load_in_ex = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0);

  assign hz = id_valid && load_in_ex &&
              ((uses_rs1 && (rs1_eff == ex_q.rd)) ||
               (uses_rs2 && (id_inst[24:20] == ex_q.rd)));

  // Evaluated only when the instruction is actually captured, so a stalled
  // ECALL uses the operand that arrives once the load has moved on.
  assign halt_now = id_valid && is_ecall && (id_rs1_data == HALT_CODE_W);

  assign stall = (state_q != ST_RUN) || hz;

  // -------------------------------------------------------------------------
  // Payload captured into EX when ID advances
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    ex_d = '0;
    if (id_valid) begin
      ex_d.valid    = 1'b1;
      ex_d.inst     = id_inst;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
      ex_d.rd       = id_inst[11:7];
      ex_d.rs1      = id_inst[19:15];
      ex_d.rs2      = id_inst[24:20];
      // ECALL travels down the pipe as a NOP: no writes, no memory access.
      if (!is_ecall) begin
        ex_d.mem_read   = id_mem_read;
        ex_d.mem_write  = id_mem_write;
        ex_d.mem_to_reg = id_mem_to_reg;
        ex_d.reg_write  = id_reg_write;
        ex_d.alu_src    = id_alu_src;
        ex_d.alu_op     = id_alu_op;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline register, halt sequencer and bubble counter
  // -------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ex_q        <= '0;
      drain_cnt_q <= '0;
      is_halted_q <= 1'b0;
      bubble_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz) begin
            ex_q     <= '0;
            bubble_q <= bubble_q + 32'd1;
          end else begin
            ex_q <= ex_d;
            if (halt_now) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= DRAIN_INIT;
            end
          end
        end

        ST_DRAIN: begin
          ex_q <= '0;
          if (drain_cnt_q == '0) begin
            state_q     <= ST_HALTED;
            is_halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - CNT_W'(1);
          end
        end

        ST_HALTED: begin
          ex_q        <= '0;
          is_halted_q <= 1'b1;
        end

        default: begin
          state_q <= ST_RUN;
          ex_q    <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ex_valid      = ex_q.valid;
  assign ex_inst       = ex_q.inst;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rd         = ex_q.rd;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;
  assign is_halted     = is_halted_q;
  assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed and randomized stimulus for id_ex_stage, compared against a
// behavioural model: EX contents as a captured record, halting expressed as
// "edge at which the halting ECALL was captured" plus the drain length.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int unsigned HALT_DRAIN = 3;
  localparam int unsigned HALT_REG   = 17;
  localparam int unsigned HALT_CODE  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_inst, id_rs1_data, id_rs2_data, id_imm;
  logic        id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_alu_src;
  logic [1:0]  id_alu_op;
  logic        ex_valid;
  logic [31:0] ex_inst, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src;
  logic [1:0]  ex_alu_op;
  logic        stall, is_halted;
  logic [31:0] bubble_count;

  always #5 clk = ~clk;

  id_ex_stage #(
    .HALT_DRAIN(HALT_DRAIN),
    .HALT_REG  (HALT_REG),
    .HALT_CODE (HALT_CODE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_inst      (id_inst),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write (id_reg_write),
    .id_alu_src   (id_alu_src),
    .id_alu_op    (id_alu_op),
    .ex_valid     (ex_valid),
    .ex_inst      (ex_inst),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_imm       (ex_imm),
    .ex_rd        (ex_rd),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write (ex_reg_write),
    .ex_alu_src   (ex_alu_src),
    .ex_alu_op    (ex_alu_op),
    .stall        (stall),
    .is_halted    (is_halted),
    .bubble_count (bubble_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [6:0]  ctl;  // {mem_read, mem_write, mem_to_reg, reg_write, alu_src, alu_op}
  } ex_t;

  ex_t m_ex;
  int  m_edges;       // edges since last reset
  int  m_halt_edge;   // edge that captured the halting ECALL, -1 if none
  int  m_bubbles;

  function automatic bit is_ecall(input logic [31:0] inst);
    return (inst[6:0] == 7'h73) && (inst[14:12] == 3'b000) && (inst[31:20] == 12'h000);
  endfunction

  function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
    case (inst[6:0])
      7'h33, 7'h23: return (r == inst[19:15]) || (r == inst[24:20]);
      7'h13, 7'h03: return r == inst[19:15];
      7'h73:        return is_ecall(inst) && (r == 5'(HALT_REG));
      default:      return 1'b0;
    endcase
  endfunction

  function automatic bit m_hz();
    return m_ex.valid && m_ex.ctl[6] && (m_ex.inst[11:7] != 5'd0) && id_valid &&
           reads_reg(id_inst, m_ex.inst[11:7]);
  endfunction

  function automatic bit m_stall();
    return (m_halt_edge >= 0) || m_hz();
  endfunction

  function automatic bit m_halted();
    return (m_halt_edge >= 0) && (m_edges >= m_halt_edge + int'(HALT_DRAIN));
  endfunction

  task automatic model_edge();
    ex_t nx;
    bit  hz;
    nx = '0;
    hz = m_hz();
    if (reset) begin
      m_ex        = '0;
      m_edges     = 0;
      m_halt_edge = -1;
      m_bubbles   = 0;
    end else begin
      m_edges++;
      if (m_halt_edge < 0) begin
        if (hz) m_bubbles++;
        else if (id_valid) begin
          nx.valid = 1'b1;
          nx.inst  = id_inst;
          nx.rs1d  = id_rs1_data;
          nx.rs2d  = id_rs2_data;
          nx.imm   = id_imm;
          nx.ctl   = is_ecall(id_inst) ? 7'b0 :
                     {id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_alu_src, id_alu_op};
          if (is_ecall(id_inst) && id_rs1_data == HALT_CODE) m_halt_edge = m_edges;
        end
      end
      m_ex = nx;
    end
  endtask

  task automatic check_outputs(input string t);
    check({t, ".ex_valid"},  32'(ex_valid),    32'(m_ex.valid));
    check({t, ".ex_inst"},   ex_inst,          m_ex.inst);
    check({t, ".ex_rs1d"},   ex_rs1_data,      m_ex.rs1d);
    check({t, ".ex_rs2d"},   ex_rs2_data,      m_ex.rs2d);
    check({t, ".ex_imm"},    ex_imm,           m_ex.imm);
    check({t, ".ex_rd"},     32'(ex_rd),       32'(m_ex.inst[11:7]));
    check({t, ".ex_rs1"},    32'(ex_rs1),      32'(m_ex.inst[19:15]));
    check({t, ".ex_rs2"},    32'(ex_rs2),      32'(m_ex.inst[24:20]));
    check({t, ".ex_ctl"},
          32'({ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_alu_op}),
          32'(m_ex.ctl));
    check({t, ".is_halted"}, 32'(is_halted),   32'(m_halted()));
    check({t, ".bubbles"},   bubble_count,     32'(m_bubbles));
  endtask

  // One clock: check combinational stall before the edge, outputs after it.
  // Inputs are expected to have been driven at the preceding falling edge.
  task automatic cycle(input string t);
    #1;
    check({t, ".stall"}, 32'(stall), 32'(m_stall()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(t);
  endtask

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1);
    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, rs1);
    return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
  endfunction
  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic drive(input logic v, input logic [31:0] inst, rs1d, rs2d, imm);
    logic [6:0] c;
    case (inst[6:0])
      7'h33:   c = 7'b0001010;
      7'h13:   c = 7'b0001110;
      7'h03:   c = 7'b1011100;
      7'h23:   c = 7'b0100100;
      7'h73:   c = 7'b0001000;  // deliberately non-zero: ECALL must clear it
      default: c = 7'b0;
    endcase
    id_valid    = v;
    id_inst     = inst;
    id_rs1_data = rs1d;
    id_rs2_data = rs2d;
    id_imm      = imm;
    {id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_alu_src, id_alu_op} = c;
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 5'(HALT_REG) : 5'(k);
  endfunction

  // ------------------------------------------------------------------------
  // Directed sequence followed by random traffic
  // ------------------------------------------------------------------------
  initial begin
    m_ex = '0; m_edges = 0; m_halt_edge = -1; m_bubbles = 0;

    // Reset with a valid instruction present.
    reset = 1'b1;
    drive(1'b1, enc_i(5'd5, 5'd1, 12'hFFC), 32'd7, 32'd0, 32'hFFFF_FFFC);
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    check_outputs("reset");
    check("reset.stall",   32'(stall),   32'd0);
    check("reset.valid",   32'(ex_valid), 32'd0);
    check("reset.bubbles", bubble_count, 32'd0);
    reset = 1'b0;

    // Pass-through: addi x5,x1,-4.
    cycle("addi");
    check("addi.rd_lit",  32'(ex_rd),      32'd5);
    check("addi.imm_lit", ex_imm,          32'hFFFF_FFFC);
    check("addi.rs1_lit", ex_rs1_data,     32'd7);
    check("addi.src_lit", 32'(ex_alu_src), 32'd1);

    // Load-use: lw x3,0(x2) ; add x4,x3,x1.
    drive(1'b1, enc_lw(5'd3, 5'd2), 32'h100, 32'd0, 32'd0);
    cycle("lw_x3");
    drive(1'b1, enc_r(5'd4, 5'd3, 5'd1), 32'h11, 32'h22, 32'd0);
    #1 check("lu.stall_lit", 32'(stall), 32'd1);
    cycle("lu_bubble");
    check("lu.valid_lit",   32'(ex_valid), 32'd0);
    check("lu.bubbles_lit", bubble_count,  32'd1);
    cycle("lu_capture");
    check("lu.rd_lit", 32'(ex_rd), 32'd4);

    // lw x0 never causes a hazard.
    drive(1'b1, enc_lw(5'd0, 5'd2), 32'h100, 32'd0, 32'd0);
    cycle("lw_x0");
    drive(1'b1, enc_r(5'd4, 5'd0, 5'd1), 32'h1, 32'h2, 32'd0);
    cycle("lw_x0_use");

    // Store whose rs2 hits the load.
    drive(1'b1, enc_lw(5'd3, 5'd2), 32'h200, 32'd0, 32'd0);
    cycle("lw_x3b");
    drive(1'b1, enc_sw(5'd3, 5'd5), 32'h300, 32'h400, 32'd0);
    cycle("sw_bubble");
    check("sw.bubbles_lit", bubble_count, 32'd2);
    cycle("sw_capture");

    // addi with rs2 field 3 must not see a false hazard.
    drive(1'b1, enc_lw(5'd3, 5'd2), 32'h200, 32'd0, 32'd0);
    cycle("lw_x3c");
    drive(1'b1, enc_i(5'd4, 5'd5, 12'h003), 32'h5, 32'd0, 32'd3);
    cycle("addi_nofalse");

    // Non-halting ECALL passes as a NOP.
    drive(1'b1, ECALL, 32'd9, 32'd0, 32'd0);
    cycle("ecall_nop");
    check("ecall_nop.valid_lit", 32'(ex_valid), 32'd1);
    check("ecall_nop.rw_lit",    32'(ex_reg_write), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    cycle("idle");

    // Halting ECALL behind a load to HALT_REG: stalls first, then uses the
    // operand delivered after the stall.
    drive(1'b1, enc_lw(5'(HALT_REG), 5'd2), 32'h0, 32'd0, 32'd0);
    cycle("lw_x17");
    drive(1'b1, ECALL, 32'd0, 32'd0, 32'd0);
    cycle("ecall_stall");
    id_rs1_data = 32'(HALT_CODE);
    cycle("ecall_capture");
    drive(1'b1, enc_i(5'd6, 5'd1, 12'h001), 32'd1, 32'd0, 32'd1);
    cycle("drain1");
    cycle("drain2");
    check("halt.early_lit", 32'(is_halted), 32'd0);
    cycle("halted");
    check("halt.set_lit", 32'(is_halted), 32'd1);
    repeat (3) cycle("halt_sticky");

    // Reset, then reset one cycle into a fresh drain.
    reset = 1'b1;
    cycle("reset2");
    reset = 1'b0;
    drive(1'b1, ECALL, 32'(HALT_CODE), 32'd0, 32'd0);
    cycle("ecall2");
    drive(1'b1, enc_i(5'd7, 5'd1, 12'h002), 32'd3, 32'd0, 32'd2);
    cycle("drain_a");
    reset = 1'b1;
    cycle("reset_mid");
    check("reset_mid.halt_lit", 32'(is_halted), 32'd0);
    reset = 1'b0;
    cycle("after_reset");
    check("after_reset.valid_lit", 32'(ex_valid), 32'd1);
    check("after_reset.rd_lit",    32'(ex_rd),    32'd7);

    // Random traffic with a small register pool so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst;
      int          k;
      inst = $urandom;
      inst[11:7]  = pick_reg();
      inst[19:15] = pick_reg();
      inst[24:20] = pick_reg();
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    inst[6:0] = 7'h33;
        2, 3:    inst[6:0] = 7'h13;
        4, 5:    inst[6:0] = 7'h03;
        6, 7:    inst[6:0] = 7'h23;
        8:       inst = ($urandom_range(0, 3) != 0) ? {12'h000, inst[19:15], 3'b000, inst[11:7], 7'h73}
                                                    : {inst[31:7], 7'h73};
        default: inst[6:0] = 7'h37;
      endcase
      id_valid    = ($urandom_range(0, 7) != 0);
      id_inst     = inst;
      k = $urandom_range(0, 2);
      id_rs1_data = (k == 0) ? 32'(HALT_CODE) : (k == 1) ? 32'd9 : 32'($urandom);
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      {id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_alu_src, id_alu_op} = 7'($urandom);
      reset = (m_halted() && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
      cycle("rand");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
